// File: rtl/regfile_sb_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Used by regfile_sb and regfile_sb_entry.
package regfile_sb_pkg;

    localparam int DW_DEF    = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    // Change in busy population for one register.
    // An issue on the same edge as a writeback wins, so set has priority.
    function automatic logic signed [1:0] pend_delta(
        input logic set,
        input logic clr,
        input logic old
    );
        if (set && !old) begin
            return 2'sb01;
        end else if (!set && clr && old) begin
            return 2'sb11;
        end else begin
            return 2'sb00;
        end
    endfunction

endpackage

// File: rtl/regfile_sb_entry.sv
// One architectural register plus its scoreboard busy bit.
// Async active-high reset clears both.
module regfile_sb_entry
    import regfile_sb_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_set,
    input  logic          i_clr,
    output logic [DW-1:0] o_q,
    output logic          o_busy
);

    logic [DW-1:0] r_q;
    logic          r_busy;

    // Data storage: capture writeback data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_wdata;
        end
    end

    // Busy bit: issue sets, writeback clears, a new producer wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else if (i_set) begin
            r_busy <= 1'b1;
        end else if (i_clr) begin
            r_busy <= 1'b0;
        end
    end

    assign o_q    = r_q;
    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with an integrated RAW scoreboard.
// Optional REGFILE_SB_BYPASS_EN: write-through forwarding on reads.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int  DW    = DW_DEF,
    parameter int  NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] asel,
    input  logic [AW-1:0] bsel,
    output logic [DW-1:0] abus,
    output logic [DW-1:0] bbus,
    output logic          abusy,
    output logic          bbusy,
    input  logic          we,
    input  logic [AW-1:0] dsel,
    input  logic [DW-1:0] dbus,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_sel,
    output logic [AW:0]   pend_cnt,
    output logic          all_idle
);

    logic [DW-1:0]    w_q [NREGS];
    logic [NREGS-1:0] w_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [AW:0]      w_delta;
    logic [AW:0]      r_pend_cnt;

    assign w_q[ZERO_REG]    = '0;
    assign w_busy[ZERO_REG] = 1'b0;
    assign w_set[ZERO_REG]  = 1'b0;
    assign w_clr[ZERO_REG]  = 1'b0;

    for (genvar i = ZERO_REG + 1; i < NREGS; i++) begin : g_ent
        assign w_set[i] = iss_en && (iss_sel == AW'(i));
        assign w_clr[i] = we && (dsel == AW'(i));

        regfile_sb_entry #(
            .DW (DW)
        ) u_ent (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_clr[i]),
            .i_wdata (dbus),
            .i_set   (w_set[i]),
            .i_clr   (w_clr[i]),
            .o_q     (w_q[i]),
            .o_busy  (w_busy[i])
        );
    end

    // Net change of the busy population this edge.
    always_comb begin
        logic signed [1:0] d;
        w_delta = '0;
        d       = '0;
        for (int k = 0; k < NREGS; k++) begin
            d       = pend_delta(w_set[k], w_clr[k], w_busy[k]);
            w_delta = w_delta + (AW+1)'(d);
        end
    end

    // Pending counter tracks popcount(busy) incrementally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_cnt <= '0;
        end else begin
            r_pend_cnt <= r_pend_cnt + w_delta;
        end
    end

    assign pend_cnt = r_pend_cnt;
    assign all_idle = (r_pend_cnt == '0);

`ifdef REGFILE_SB_BYPASS_EN
    logic w_fwd_a;
    logic w_fwd_b;

    // Forward writeback data to readers of the same register.
    always_comb begin
        w_fwd_a = we && (dsel != AW'(ZERO_REG)) && (asel == dsel);
        w_fwd_b = we && (dsel != AW'(ZERO_REG)) && (bsel == dsel);
        abus    = w_fwd_a ? dbus : w_q[asel];
        bbus    = w_fwd_b ? dbus : w_q[bsel];
        abusy   = w_fwd_a ? 1'b0 : w_busy[asel];
        bbusy   = w_fwd_b ? 1'b0 : w_busy[bsel];
    end
`else
    // Plain reads of stored contents and busy bits.
    always_comb begin
        abus  = w_q[asel];
        bbus  = w_q[bsel];
        abusy = w_busy[asel];
        bbusy = w_busy[bsel];
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-style bench for regfile_sb.
// Expectations queued by stimulus, compared by a monitor at negedge.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  asel = '0;
    logic [4:0]  bsel = '0;
    logic [31:0] abus;
    logic [31:0] bbus;
    logic        abusy;
    logic        bbusy;
    logic        we = 1'b0;
    logic [4:0]  dsel = '0;
    logic [31:0] dbus = '0;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_sel = '0;
    logic [5:0]  pend_cnt;
    logic        all_idle;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        ab;
        logic        bb;
        logic [5:0]  pc;
        logic        idle;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_sb dut (
        .clk      (clk),
        .rst      (rst),
        .asel     (asel),
        .bsel     (bsel),
        .abus     (abus),
        .bbus     (bbus),
        .abusy    (abusy),
        .bbusy    (bbusy),
        .we       (we),
        .dsel     (dsel),
        .dbus     (dbus),
        .iss_en   (iss_en),
        .iss_sel  (iss_sel),
        .pend_cnt (pend_cnt),
        .all_idle (all_idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string n, input logic [31:0] a,
                             input logic [31:0] b, input logic ab,
                             input logic bb, input logic [5:0] pc);
        exp_t e;
        e.name = n;
        e.a    = a;
        e.b    = b;
        e.ab   = ab;
        e.bb   = bb;
        e.pc   = pc;
        e.idle = (pc == 6'd0);
        q.push_back(e);
    endtask

    task automatic idle_in();
        we     = 1'b0;
        iss_en = 1'b0;
    endtask

    // Monitor: compare every queued expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({abus, bbus, abusy, bbusy, pend_cnt, all_idle} !==
                    {e.a, e.b, e.ab, e.bb, e.pc, e.idle}) begin
                    errors++;
                    $display("FAIL %s: got a=%h b=%h ab=%b bb=%b pc=%0d idle=%b want a=%h b=%h ab=%b bb=%b pc=%0d idle=%b",
                             e.name, abus, bbus, abusy, bbusy, pend_cnt, all_idle,
                             e.a, e.b, e.ab, e.bb, e.pc, e.idle);
                end
            end
        end
    end

    initial begin
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            asel = 5'(i);
            bsel = 5'(31 - i);
            expect_rd("reset_read", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
            step();
        end

        we = 1'b1; dsel = 5'd5; dbus = 32'hDEADBEEF;
        asel = 5'd0; bsel = 5'd0;
        step();
        idle_in();
        asel = 5'd5; bsel = 5'd0;
        expect_rd("wr_r5", 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 6'd0);
        step();

        we = 1'b1; dsel = 5'd0; dbus = 32'h1234;
        asel = 5'd0; bsel = 5'd5;
        expect_rd("wr_r0_same", 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0);
        step();
        idle_in();
        expect_rd("wr_r0_after", 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0);
        step();

        iss_en = 1'b1; iss_sel = 5'd0;
        expect_rd("iss_r0_same", 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0);
        step();
        iss_sel = 5'd3;
        asel = 5'd0;
        expect_rd("iss_r0_after", 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0);
        step();
        iss_sel = 5'd7;
        asel = 5'd3; bsel = 5'd7;
        expect_rd("iss_r3", 32'h0, 32'h0, 1'b1, 1'b0, 6'd1);
        step();
        iss_sel = 5'd3;
        expect_rd("iss_r7", 32'h0, 32'h0, 1'b1, 1'b1, 6'd2);
        step();
        idle_in();
        expect_rd("reiss_r3", 32'h0, 32'h0, 1'b1, 1'b1, 6'd2);
        step();

        we = 1'b1; dsel = 5'd3; dbus = 32'h33;
        asel = 5'd7; bsel = 5'd5;
        expect_rd("wb_r3_same", 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 6'd2);
        step();
        idle_in();
        asel = 5'd3; bsel = 5'd7;
        expect_rd("wb_r3_after", 32'h33, 32'h0, 1'b0, 1'b1, 6'd1);
        step();

        iss_en = 1'b1; iss_sel = 5'd9;
        we = 1'b1; dsel = 5'd9; dbus = 32'hA5;
        expect_rd("conf_idle_same", 32'h33, 32'h0, 1'b0, 1'b1, 6'd1);
        step();
        idle_in();
        asel = 5'd9; bsel = 5'd7;
        expect_rd("conf_idle_after", 32'hA5, 32'h0, 1'b1, 1'b1, 6'd2);
        step();

        iss_en = 1'b1; iss_sel = 5'd9;
        we = 1'b1; dsel = 5'd9; dbus = 32'h5A;
        asel = 5'd7; bsel = 5'd3;
        expect_rd("conf_busy_same", 32'h0, 32'h33, 1'b1, 1'b0, 6'd2);
        step();
        idle_in();
        asel = 5'd9;
        expect_rd("conf_busy_after", 32'h5A, 32'h33, 1'b1, 1'b0, 6'd2);
        step();

        we = 1'b1; dsel = 5'd7; dbus = 32'h77;
        iss_en = 1'b1; iss_sel = 5'd11;
        asel = 5'd3; bsel = 5'd5;
        expect_rd("net0_same", 32'h33, 32'hDEADBEEF, 1'b0, 1'b0, 6'd2);
        step();
        idle_in();
        asel = 5'd7; bsel = 5'd11;
        expect_rd("net0_after", 32'h77, 32'h0, 1'b0, 1'b1, 6'd2);
        step();

        we = 1'b1; dsel = 5'd5; dbus = 32'h55;
        asel = 5'd3; bsel = 5'd3;
        expect_rd("wb_idle_same", 32'h33, 32'h33, 1'b0, 1'b0, 6'd2);
        step();
        idle_in();
        asel = 5'd5; bsel = 5'd9;
        expect_rd("wb_idle_after", 32'h55, 32'h5A, 1'b0, 1'b1, 6'd2);
        step();

        iss_en = 1'b1; iss_sel = 5'd4;
        step();
        idle_in();
        we = 1'b1; dsel = 5'd4; dbus = 32'h77;
        asel = 5'd4; bsel = 5'd4;
`ifdef REGFILE_SB_BYPASS_EN
        expect_rd("bypass_same", 32'h77, 32'h77, 1'b0, 1'b0, 6'd3);
`else
        expect_rd("bypass_same", 32'h0, 32'h0, 1'b1, 1'b1, 6'd3);
`endif
        step();
        idle_in();
        expect_rd("bypass_after", 32'h77, 32'h77, 1'b0, 1'b0, 6'd2);
        step();

        for (int i = 1; i < 32; i++) begin
            iss_en  = 1'b1;
            iss_sel = 5'(i);
            step();
        end
        idle_in();
        asel = 5'd31; bsel = 5'd1;
        expect_rd("all_busy", 32'h0, 32'h0, 1'b1, 1'b1, 6'd31);
        step();

        asel = 5'd5; bsel = 5'd9;
        #2;
        rst = 1'b1;
        #1;
        expect_rd("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        step();
        iss_en = 1'b1; iss_sel = 5'd6;
        we = 1'b1; dsel = 5'd6; dbus = 32'hFFFF;
        step();
        idle_in();
        asel = 5'd6; bsel = 5'd7;
        expect_rd("rst_discard", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        step();
        rst = 1'b0;
        asel = 5'd6; bsel = 5'd3;
        expect_rd("post_rst", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        step();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
